// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The FSM encoding is fixed because STATE is exported for debug.
package pipe_hazard_ctrl_pkg;

  // FSM states, fixed 2-bit encoding.
  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StFlush = 2'd2,
    StMwait = 2'd3
  } hz_state_e;

  // Width and saturation point of the consecutive-stall counter.
  localparam int unsigned StallCntW   = 4;
  localparam logic [StallCntW-1:0] StallCntMax = 4'd15;

  // Per-stage pipeline register controls.
  typedef struct packed {
    logic pc_en;
    logic fd_en;
    logic fd_flush;
    logic de_en;
    logic de_bubble;
    logic em_en;
    logic mw_en;
  } stage_ctrl_t;

  // Every register loads, nothing is squashed.
  localparam stage_ctrl_t CtrlRun = '{
    pc_en: 1'b1, fd_en: 1'b1, fd_flush: 1'b0, de_en: 1'b1,
    de_bubble: 1'b0, em_en: 1'b1, mw_en: 1'b1
  };

  // Whole pipe frozen while data memory is busy.
  localparam stage_ctrl_t CtrlFreeze = '{
    pc_en: 1'b0, fd_en: 1'b0, fd_flush: 1'b0, de_en: 1'b0,
    de_bubble: 1'b0, em_en: 1'b0, mw_en: 1'b0
  };

  // Redirect: load branch target, squash IF/ID and ID/EX.
  localparam stage_ctrl_t CtrlFlush = '{
    pc_en: 1'b1, fd_en: 1'b1, fd_flush: 1'b1, de_en: 1'b1,
    de_bubble: 1'b1, em_en: 1'b1, mw_en: 1'b1
  };

  // RAW stall: hold PC and IF/ID, inject a bubble into ID/EX.
  localparam stage_ctrl_t CtrlStall = '{
    pc_en: 1'b0, fd_en: 1'b0, fd_flush: 1'b0, de_en: 1'b1,
    de_bubble: 1'b1, em_en: 1'b1, mw_en: 1'b1
  };

  // Saturating increment for the stall counter.
  function automatic logic [StallCntW-1:0] sat_inc(input logic [StallCntW-1:0] val);
    return (val == StallCntMax) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_perf_counter.sv
// Enable-increment counter with synchronous active-high reset.
// Wraps from all-ones back to zero.
module pipe_perf_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: advance when enabled, natural wrap on overflow.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register, reset wins over enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: turns stall, redirect and memory-busy events
// into enable/flush/bubble controls for the PC, FD, DE, EM and MW registers.
// Outputs are Mealy (state plus current inputs); the FSM moves on the edge.
// Optional macro PIPE_PERF_CNT_EN adds STALL_CNT, FLUSH_CNT and MWAIT_CNT.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MAX_STALL = 4
`ifdef PIPE_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W     = 16
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             STALL_PROCESSOR,
  input  logic             BRANCH_TAKEN,
  input  logic             MEM_BUSY,
  output logic             PC_EN,
  output logic             FD_EN,
  output logic             FD_FLUSH,
  output logic             DE_EN,
  output logic             DE_BUBBLE,
  output logic             EM_EN,
  output logic             MW_EN,
  output logic             HAZARD_ERR,
  output logic [1:0]       STATE
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT,
  output logic [CNT_W-1:0] MWAIT_CNT
`endif
);

  localparam logic [StallCntW-1:0] MaxStallCnt = StallCntW'(MAX_STALL);

  hz_state_e              state_q, state_d;
  logic [StallCntW-1:0]   stall_cnt_q, stall_cnt_d;
  logic                   err_q, err_d;
  stage_ctrl_t            ctrl;

  // Event strobes for the optional performance counters.
  logic                   stall_ins;
  logic                   branch_acc;
  logic                   mem_wait;

  // The stage in FLUSH still holds the wrong-path instruction's sources.
  logic                   stall_masked;
  assign stall_masked = (state_q == StFlush);

  // Priority decode: reset > memory busy > branch > stall > run.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    err_d       = err_q;
    ctrl        = CtrlRun;
    stall_ins   = 1'b0;
    branch_acc  = 1'b0;
    mem_wait    = 1'b0;

    if (RST) begin
      // Load NOPs everywhere while held in reset.
      ctrl        = CtrlFlush;
      state_d     = StRun;
      stall_cnt_d = '0;
      err_d       = 1'b0;
    end else if (MEM_BUSY) begin
      // Pending branch/stall is re-presented by the frozen producer.
      ctrl        = CtrlFreeze;
      state_d     = StMwait;
      mem_wait    = 1'b1;
    end else if (BRANCH_TAKEN) begin
      ctrl        = CtrlFlush;
      state_d     = StFlush;
      stall_cnt_d = '0;
      branch_acc  = 1'b1;
    end else if (STALL_PROCESSOR && !stall_masked) begin
      ctrl        = CtrlStall;
      state_d     = StStall;
      stall_cnt_d = sat_inc(stall_cnt_q);
      stall_ins   = 1'b1;
    end else begin
      ctrl        = CtrlRun;
      state_d     = StRun;
      stall_cnt_d = '0;
    end

    // Runaway-stall watchdog, sticky until reset; stalling carries on.
    if (!RST && (stall_cnt_d >= MaxStallCnt)) begin
      err_d = 1'b1;
    end
  end

  // FSM, stall counter and error flag registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StRun;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign PC_EN      = ctrl.pc_en;
  assign FD_EN      = ctrl.fd_en;
  assign FD_FLUSH   = ctrl.fd_flush;
  assign DE_EN      = ctrl.de_en;
  assign DE_BUBBLE  = ctrl.de_bubble;
  assign EM_EN      = ctrl.em_en;
  assign MW_EN      = ctrl.mw_en;
  assign HAZARD_ERR = err_q;
  assign STATE      = state_q;

`ifdef PIPE_PERF_CNT_EN
  pipe_perf_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i (CLK),
    .rst_i (RST),
    .en_i  (stall_ins),
    .cnt_o (STALL_CNT)
  );

  pipe_perf_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk_i (CLK),
    .rst_i (RST),
    .en_i  (branch_acc),
    .cnt_o (FLUSH_CNT)
  );

  pipe_perf_counter #(
    .CNT_W (CNT_W)
  ) u_mwait_cnt (
    .clk_i (CLK),
    .rst_i (RST),
    .en_i  (mem_wait),
    .cnt_o (MWAIT_CNT)
  );
`else
  // Strobes only feed the optional counters.
  logic unused_perf;
  assign unused_perf = stall_ins ^ branch_acc ^ mem_wait;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a driver issues directed then random
// events and queues the expected response from a behavioural model; a monitor
// on the falling edge pops and compares.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MaxStall = 4;
  localparam int unsigned CntW     = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic STALL_PROCESSOR = 1'b0;
  logic BRANCH_TAKEN = 1'b0;
  logic MEM_BUSY = 1'b0;
  logic PC_EN, FD_EN, FD_FLUSH, DE_EN, DE_BUBBLE, EM_EN, MW_EN, HAZARD_ERR;
  logic [1:0] STATE;
`ifdef PIPE_PERF_CNT_EN
  logic [CntW-1:0] STALL_CNT, FLUSH_CNT, MWAIT_CNT;
`endif

  pipe_hazard_ctrl #(
    .MAX_STALL (MaxStall)
`ifdef PIPE_PERF_CNT_EN
    ,
    .CNT_W     (CntW)
`endif
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .STALL_PROCESSOR (STALL_PROCESSOR),
    .BRANCH_TAKEN    (BRANCH_TAKEN),
    .MEM_BUSY        (MEM_BUSY),
    .PC_EN           (PC_EN),
    .FD_EN           (FD_EN),
    .FD_FLUSH        (FD_FLUSH),
    .DE_EN           (DE_EN),
    .DE_BUBBLE       (DE_BUBBLE),
    .EM_EN           (EM_EN),
    .MW_EN           (MW_EN),
    .HAZARD_ERR      (HAZARD_ERR),
    .STATE           (STATE)
`ifdef PIPE_PERF_CNT_EN
    ,
    .STALL_CNT       (STALL_CNT),
    .FLUSH_CNT       (FLUSH_CNT),
    .MWAIT_CNT       (MWAIT_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  // ctrl = {PC_EN, FD_EN, FD_FLUSH, DE_EN, DE_BUBBLE, EM_EN, MW_EN}
  typedef struct packed {
    logic [6:0] ctrl;
    logic [1:0] st;
    logic       err;
    logic [3:0] pst;
    logic [3:0] pfl;
    logic [3:0] pmw;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: state number, consecutive stall run, sticky error, counts.
  int m_st   = 0;
  int m_run  = 0;
  bit m_err  = 1'b0;
  int m_pst  = 0;
  int m_pfl  = 0;
  int m_pmw  = 0;

  task automatic step(input bit r, input bit mb, input bit br, input bit sb);
    exp_t e;
    @(posedge CLK);
    #1;
    RST = r; MEM_BUSY = mb; BRANCH_TAKEN = br; STALL_PROCESSOR = sb;
    e.st  = 2'(m_st);
    e.err = m_err;
    e.pst = 4'(m_pst % 16);
    e.pfl = 4'(m_pfl % 16);
    e.pmw = 4'(m_pmw % 16);
    if (r) begin
      e.ctrl = 7'b1111111;
      m_st = 0; m_run = 0; m_err = 1'b0; m_pst = 0; m_pfl = 0; m_pmw = 0;
    end else if (mb) begin
      e.ctrl = 7'b0000000;
      m_st = 3; m_pmw++;
    end else if (br) begin
      e.ctrl = 7'b1111111;
      m_st = 2; m_run = 0; m_pfl++;
    end else if (sb && m_st != 2) begin
      e.ctrl = 7'b0001111;
      m_st = 1; m_pst++;
      m_run = (m_run < 15) ? m_run + 1 : 15;
      if (m_run >= MaxStall) m_err = 1'b1;
    end else begin
      e.ctrl = 7'b1101011;
      m_st = 0; m_run = 0;
    end
    q.push_back(e);
  endtask

  // Monitor: compare every queued expectation mid-cycle.
  always @(negedge CLK) begin
    exp_t e;
    logic [6:0] act;
    if (q.size() > 0) begin
      e = q.pop_front();
      act = {PC_EN, FD_EN, FD_FLUSH, DE_EN, DE_BUBBLE, EM_EN, MW_EN};
      n_cmp++;
      if (act !== e.ctrl) begin
        n_bad++;
        $display("FAIL ctrl t=%0t got=%b want=%b", $time, act, e.ctrl);
      end
      n_cmp++;
      if (STATE !== e.st) begin
        n_bad++;
        $display("FAIL state t=%0t got=%0d want=%0d", $time, STATE, e.st);
      end
      n_cmp++;
      if (HAZARD_ERR !== e.err) begin
        n_bad++;
        $display("FAIL hazard_err t=%0t got=%b want=%b", $time, HAZARD_ERR, e.err);
      end
`ifdef PIPE_PERF_CNT_EN
      n_cmp++;
      if (STALL_CNT !== e.pst) begin
        n_bad++;
        $display("FAIL stall_cnt t=%0t got=%0d want=%0d", $time, STALL_CNT, e.pst);
      end
      n_cmp++;
      if (FLUSH_CNT !== e.pfl) begin
        n_bad++;
        $display("FAIL flush_cnt t=%0t got=%0d want=%0d", $time, FLUSH_CNT, e.pfl);
      end
      n_cmp++;
      if (MWAIT_CNT !== e.pmw) begin
        n_bad++;
        $display("FAIL mwait_cnt t=%0t got=%0d want=%0d", $time, MWAIT_CNT, e.pmw);
      end
`endif
    end
  end

  // Directed events {rst, mem_busy, branch, stall}.
  logic [3:0] dir [];

  initial begin
    int hold;
    int r;
    bit sb, br, mb, rs;
    dir = '{
      4'b0000, 4'b0000,                          // idle after reset
      4'b0001, 4'b0001, 4'b0000,                 // two stalls, release
      4'b0011, 4'b0001, 4'b0000,                 // branch over stall, masked stall
      4'b0110, 4'b0110, 4'b0110, 4'b0010,        // freeze hides branch, then flush
      4'b0000,
      4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, // watchdog
      4'b1000, 4'b0000,
      4'b0001, 4'b0001, 4'b0001, 4'b0000,        // just under the limit
      4'b0010, 4'b0010, 4'b0000,                 // branch while flushing
      4'b0010, 4'b0100, 4'b0001, 4'b0000,        // no mask after memory wait
      4'b1000
    };
    // Hold reset for two edges before the scoreboard starts.
    repeat (2) @(posedge CLK);
    foreach (dir[i]) step(dir[i][3], dir[i][2], dir[i][1], dir[i][0]);
    // 17 consecutive stalls wrap a 4-bit stall counter.
    repeat (17) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      r  = int'($urandom_range(0, 99));
      rs = (r == 0);
      mb = ($urandom_range(0, 99) < 12);
      br = ($urandom_range(0, 99) < 12);
      sb = ($urandom_range(0, 99) < 55);
      if (hold == 0 && $urandom_range(0, 39) == 0) hold = 7;
      if (hold > 0) begin
        hold--;
        rs = 1'b0; br = 1'b0; sb = 1'b1;
      end
      step(rs, mb, br, sb);
    end

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge CLK);
    @(posedge CLK);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
